// File: rtl/hog_seq_pkg.sv
// Shared state type and derived geometry for the HOG window sequencer.
// HOG_SEQ_BORDER_REPLICATE_EN switches the geometry to full-frame, edge-replicated output.
package hog_seq_pkg;

    typedef enum logic {FILL = 1'b0, SWEEP = 1'b1} state_t;

    function automatic int idx(input int r, input int c);
        return 3 * r + c;
    endfunction

`ifdef HOG_SEQ_BORDER_REPLICATE_EN
    function automatic int span_of(input int row_pix);
        return row_pix;
    endfunction

    function automatic int orows_of(input int frame_rows);
        return frame_rows;
    endfunction
`else
    function automatic int span_of(input int row_pix);
        return row_pix - 2;
    endfunction

    function automatic int orows_of(input int frame_rows);
        return frame_rows - 2;
    endfunction
`endif

    function automatic int beats_of(input int row_pix, input int lanes);
        return span_of(row_pix) / lanes;
    endfunction

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hog_window_sequencer_extract.sv
// Combinational window builder: LANES adjacent 3x3 windows from three buffered rows.
// HOG_SEQ_BORDER_REPLICATE_EN adds column clamping to the nearest edge pixel.
module hog_win_extract import hog_seq_pkg::*; #(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 70,
    parameter int LANES   = 4,
    parameter int CW      = 1
) (
    input  logic [ROW_PIX*PIX_W-1:0]   row_top,
    input  logic [ROW_PIX*PIX_W-1:0]   row_mid,
    input  logic [ROW_PIX*PIX_W-1:0]   row_bot,
    input  logic [CW-1:0]              beat,
    output logic [LANES*9*PIX_W-1:0]   win
);

    logic [ROW_PIX*PIX_W-1:0] rows [3];

    assign rows[0] = row_top;
    assign rows[1] = row_mid;
    assign rows[2] = row_bot;

    always_comb begin : build
        int col;
        col = 0;
        win = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
`ifdef HOG_SEQ_BORDER_REPLICATE_EN
                    // Centre column is beat*LANES+k; neighbours clamp to the row edges.
                    col = int'(beat) * LANES + k + c - 1;
                    if (col < 0)
                        col = 0;
                    else if (col > ROW_PIX - 1)
                        col = ROW_PIX - 1;
`else
                    col = int'(beat) * LANES + k + c;
`endif
                    win[(k*9 + idx(r, c))*PIX_W +: PIX_W] = rows[r][col*PIX_W +: PIX_W];
                end
            end
        end
    end

endmodule

// File: rtl/hog_window_sequencer.sv
// Row-stream front end: 3-row line buffer, FILL/SWEEP sequencing, LANES windows per beat.
// Build option HOG_SEQ_BORDER_REPLICATE_EN emits every centre with edge replication.
module hog_window_sequencer import hog_seq_pkg::*; #(
    parameter int  PIX_W      = 8,
    parameter int  ROW_PIX    = 70,
    parameter int  FRAME_ROWS = 160,
    parameter int  LANES      = 4,
    localparam int BEATS      = beats_of(ROW_PIX, LANES),
    localparam int OROWS      = orows_of(FRAME_ROWS),
    localparam int RW         = width_of(FRAME_ROWS),
    localparam int CW         = width_of(BEATS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROW_PIX*PIX_W-1:0]   in_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*9*PIX_W-1:0]   win_out,
    output logic [RW-1:0]              cnt_row,
    output logic [CW-1:0]              cnt_col,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic                       out_eof
);

    if (span_of(ROW_PIX) % LANES != 0) begin : g_bad_lanes
        $error("hog_window_sequencer: row span not divisible by LANES");
    end
    if (FRAME_ROWS < 3) begin : g_bad_rows
        $error("hog_window_sequencer: FRAME_ROWS must be at least 3");
    end

    state_t                    state;
    logic [1:0]                occ;
    logic [1:0]                occ_next;
    logic [1:0]                occ_target;
    logic [ROW_PIX*PIX_W-1:0]  r0, r1, r2, row_top;
    logic [LANES*9*PIX_W-1:0]  win_raw;
    logic                      kill, in_hs, out_hs, last_col, last_row, shift_in;

    assign kill     = rst | frame_abort;
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign last_col = (cnt_col == CW'(BEATS - 1));
    assign last_row = (cnt_row == RW'(OROWS - 1));
    assign occ_next = occ + 2'd1;

`ifdef HOG_SEQ_BORDER_REPLICATE_EN
    // Centre 0 replicates row 0 upward; the final centre reuses the newest row as its bottom.
    assign occ_target = (cnt_row == '0) ? 2'd2 : 2'd3;
    assign shift_in   = out_hs & last_col & (cnt_row == RW'(FRAME_ROWS - 2));
    assign row_top    = (cnt_row == '0) ? r1 : r0;
`else
    assign occ_target = 2'd3;
    assign shift_in   = 1'b0;
    assign row_top    = r0;
`endif

    assign out_sof = out_valid & (cnt_row == '0) & (cnt_col == '0);
    assign out_eol = out_valid & last_col;
    assign out_eof = out_valid & last_col & last_row;
    assign win_out = out_valid ? win_raw : '0;

    always_ff @(posedge clk) begin
        if (kill) begin
            state     <= FILL;
            occ       <= '0;
            cnt_row   <= '0;
            cnt_col   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_hs) begin
                        occ <= occ_next;
                        if (occ_next == occ_target) begin
                            state     <= SWEEP;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (out_hs) begin
                        if (!last_col) begin
                            cnt_col <= cnt_col + 1'b1;
                        end else begin
                            cnt_col <= '0;
                            if (last_row) begin
                                state     <= FILL;
                                occ       <= '0;
                                cnt_row   <= '0;
                                in_ready  <= 1'b1;
                                out_valid <= 1'b0;
                            end else begin
                                cnt_row <= cnt_row + 1'b1;
                                if (!shift_in) begin
                                    state     <= FILL;
                                    occ       <= 2'd2;
                                    in_ready  <= 1'b1;
                                    out_valid <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Line buffer has no reset: occupancy alone decides which rows are meaningful.
    always_ff @(posedge clk) begin
        if (!kill && in_hs) begin
            r0 <= r1;
            r1 <= r2;
            r2 <= in_row;
        end else if (!kill && shift_in) begin
            r0 <= r1;
            r1 <= r2;
        end
    end

    hog_win_extract #(
        .PIX_W   (PIX_W),
        .ROW_PIX (ROW_PIX),
        .LANES   (LANES),
        .CW      (CW)
    ) u_extract (
        .row_top (row_top),
        .row_mid (r1),
        .row_bot (r2),
        .beat    (cnt_col),
        .win     (win_raw)
    );

endmodule
